// File: rtl/uart_rx_led_pkg.sv
// Shared definitions for the UART/LED remote-control path: receiver state
// encodings, bit-timing derivation and default clocking.
package uart_rx_led_pkg;

  localparam int DEFAULT_CLK_FREQ  = 25_000_000;
  localparam int DEFAULT_BAUD_RATE = 115_200;

  localparam int CNT_W     = 16;
  localparam int BIT_IDX_W = 3;

  typedef logic [CNT_W-1:0]     baud_cnt_t;
  typedef logic [BIT_IDX_W-1:0] bit_idx_t;
  typedef logic [7:0]           rx_byte_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

  function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int calc_half_bit(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/uart_rx_led_if.sv
// Serial line in, received byte stream out; the receiver is the master side.
interface uart_rx_led_if;
  import uart_rx_led_pkg::*;

  logic     rx;
  rx_byte_t data_out;
  logic     data_valid;
  logic     frame_error;
  logic     busy;

  modport master (input rx, output data_out, data_valid, frame_error, busy);
  modport slave  (output rx, input data_out, data_valid, frame_error, busy);

endinterface

// File: rtl/uart_rx_led_sync_2ff.sv
// Generic two-flop synchronizer for asynchronous inputs; the reset value is
// chosen by the caller so an idle line does not look like activity.
module sync_2ff #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_led.sv
// 8N1 UART receiver feeding the LED blink stage: centre-sampled bits,
// start-glitch rejection, framing-error pulse and break-hold handling.
module uart_rx_led
  import uart_rx_led_pkg::*;
#(
  parameter int CLK_FREQ  = DEFAULT_CLK_FREQ,
  parameter int BAUD_RATE = DEFAULT_BAUD_RATE
) (
  input logic           clk,
  input logic           rst_n,
  uart_rx_led_if.master bus
);

  localparam int        CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int        HALF         = calc_half_bit(CLKS_PER_BIT);
  localparam baud_cnt_t BIT_LAST     = baud_cnt_t'(CLKS_PER_BIT - 1);
  localparam baud_cnt_t HALF_LAST    = baud_cnt_t'(HALF - 1);

  logic      rx_s;
  rx_state_e state;
  baud_cnt_t cnt;
  bit_idx_t  bit_idx;
  rx_byte_t  shift;

  sync_2ff #(
    .WIDTH       (1),
    .RESET_VALUE (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.rx),
    .q     (rx_s)
  );

  // Pulses default low every cycle; busy is updated alongside each state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      bit_idx         <= '0;
      shift           <= '0;
      bus.data_out    <= '0;
      bus.data_valid  <= 1'b0;
      bus.frame_error <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      bus.data_valid  <= 1'b0;
      bus.frame_error <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state    <= START;
            cnt      <= '0;
            bus.busy <= 1'b1;
          end
        end

        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state    <= IDLE;
              bus.busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + baud_cnt_t'(1);
          end
        end

        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt            <= '0;
            shift[bit_idx] <= rx_s;
            if (bit_idx == bit_idx_t'(7)) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + bit_idx_t'(1);
            end
          end else begin
            cnt <= cnt + baud_cnt_t'(1);
          end
        end

        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              bus.data_out   <= shift;
              bus.data_valid <= 1'b1;
              state          <= IDLE;
              bus.busy       <= 1'b0;
            end else begin
              bus.frame_error <= 1'b1;
              state           <= BREAK;
            end
          end else begin
            cnt <= cnt + baud_cnt_t'(1);
          end
        end

        // A held-low line must return high before another start edge counts.
        BREAK: begin
          if (rx_s) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end

        default: begin
          state    <= IDLE;
          cnt      <= '0;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

  a_pulse_exclusive : assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.data_valid && bus.frame_error));

endmodule

// File: tb/tb_uart_rx_led.sv
// Directed bench for uart_rx_led at 10 clocks per bit: reset, single and
// back-to-back frames, start glitch, framing error with break, mid-frame reset.
module tb_uart_rx_led;

  localparam int BIT_CLKS = 10;

  logic clk = 1'b0;
  logic rst_n;

  int checkCount     = 0;
  int passCount      = 0;
  int cycleCount     = 0;
  int validCount     = 0;
  int errCount       = 0;
  int bothCount      = 0;
  int lastValidCycle = 0;
  int lastStartCycle = 0;
  logic [7:0] validQ[$];

  uart_rx_led_if bus();

  uart_rx_led #(
    .CLK_FREQ  (1_000_000),
    .BAUD_RATE (100_000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  // Output monitor, sampled on the falling edge so each one-cycle pulse is seen once.
  always @(negedge clk) begin
    if (bus.data_valid) begin
      validQ.push_back(bus.data_out);
      validCount++;
      lastValidCycle = cycleCount;
    end
    if (bus.frame_error) errCount++;
    if (bus.data_valid && bus.frame_error) bothCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  function automatic logic [31:0] byteAt(input int idx);
    return (idx < validQ.size()) ? 32'(validQ[idx]) : 32'hDEAD_BEEF;
  endfunction

  task automatic driveBit(input logic b);
    bus.rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  // Sends one full frame; must be entered on a falling edge and leaves on one.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
    lastStartCycle = cycleCount;
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(data[i]);
    driveBit(stopBit);
  endtask

  logic [7:0] b2b[4] = '{8'h01, 8'h80, 8'hFF, 8'h00};
  logic [7:0] abortByte = 8'hC3;
  int baseQ, baseV, baseE;

  initial begin
    rst_n  = 1'b0;
    bus.rx = 1'b1;

    $display("[TB] reset");
    repeat (3) @(negedge clk);
    checkOutput("rst_data_out", 32'(bus.data_out), 32'h00);
    checkOutput("rst_data_valid", 32'(bus.data_valid), 32'h0);
    checkOutput("rst_frame_error", 32'(bus.frame_error), 32'h0);
    checkOutput("rst_busy", 32'(bus.busy), 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("post_rst_data_out", 32'(bus.data_out), 32'h00);
    checkOutput("post_rst_busy", 32'(bus.busy), 32'h0);
    checkOutput("post_rst_valid_count", 32'(validCount), 32'd0);

    $display("[TB] single frame A5");
    baseQ = validQ.size(); baseV = validCount; baseE = errCount;
    applyStimulus(8'hA5, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("single_count", 32'(validCount - baseV), 32'd1);
    checkOutput("single_byte", byteAt(baseQ), 32'hA5);
    checkOutput("single_data_out", 32'(bus.data_out), 32'hA5);
    checkOutput("single_latency_ok",
                32'((lastValidCycle - lastStartCycle >= 95) && (lastValidCycle - lastStartCycle <= 99)), 32'd1);
    checkOutput("single_busy", 32'(bus.busy), 32'h0);
    checkOutput("single_no_err", 32'(errCount - baseE), 32'd0);

    $display("[TB] asynchronous reset between edges");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_data_out", 32'(bus.data_out), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] back-to-back frames");
    baseQ = validQ.size(); baseV = validCount; baseE = errCount;
    for (int i = 0; i < 4; i++) applyStimulus(b2b[i], 1'b1);
    repeat (5) @(negedge clk);
    checkOutput("b2b_count", 32'(validCount - baseV), 32'd4);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("b2b_byte%0d", i), byteAt(baseQ + i), 32'(b2b[i]));
    checkOutput("b2b_no_err", 32'(errCount - baseE), 32'd0);
    checkOutput("b2b_busy", 32'(bus.busy), 32'h0);

    $display("[TB] start glitch");
    baseV = validCount; baseE = errCount;
    bus.rx = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("glitch_busy_high", 32'(bus.busy), 32'h1);
    bus.rx = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("glitch_busy_low", 32'(bus.busy), 32'h0);
    checkOutput("glitch_no_valid", 32'(validCount - baseV), 32'd0);
    checkOutput("glitch_no_err", 32'(errCount - baseE), 32'd0);

    $display("[TB] framing error and break");
    applyStimulus(8'h69, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("fe_prev_data_out", 32'(bus.data_out), 32'h69);
    baseQ = validQ.size(); baseV = validCount; baseE = errCount;
    applyStimulus(8'h3C, 1'b0);
    checkOutput("fe_err_count", 32'(errCount - baseE), 32'd1);
    checkOutput("fe_no_valid", 32'(validCount - baseV), 32'd0);
    checkOutput("fe_data_out_held", 32'(bus.data_out), 32'h69);
    repeat (50) @(negedge clk);
    checkOutput("brk_busy", 32'(bus.busy), 32'h1);
    checkOutput("brk_no_valid", 32'(validCount - baseV), 32'd0);
    checkOutput("brk_err_once", 32'(errCount - baseE), 32'd1);
    bus.rx = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("brk_release_busy", 32'(bus.busy), 32'h0);
    applyStimulus(8'h5A, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("fe_next_count", 32'(validCount - baseV), 32'd1);
    checkOutput("fe_next_byte", byteAt(baseQ), 32'h5A);
    checkOutput("fe_next_data_out", 32'(bus.data_out), 32'h5A);

    $display("[TB] reset mid-frame");
    baseQ = validQ.size(); baseV = validCount; baseE = errCount;
    driveBit(1'b0);
    for (int i = 0; i < 4; i++) driveBit(abortByte[i]);
    bus.rx = abortByte[4];
    repeat (5) @(negedge clk);
    checkOutput("abort_busy_before", 32'(bus.busy), 32'h1);
    rst_n  = 1'b0;
    bus.rx = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("abort_rst_data_out", 32'(bus.data_out), 32'h00);
    checkOutput("abort_rst_busy", 32'(bus.busy), 32'h0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("abort_no_valid", 32'(validCount - baseV), 32'd0);
    checkOutput("abort_no_err", 32'(errCount - baseE), 32'd0);
    applyStimulus(8'h12, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("abort_next_count", 32'(validCount - baseV), 32'd1);
    checkOutput("abort_next_byte", byteAt(baseQ), 32'h12);
    checkOutput("abort_next_data_out", 32'(bus.data_out), 32'h12);

    checkOutput("pulses_exclusive", 32'(bothCount), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/uart_rx_led.md
Name: uart_rx_led

Overview:
- UART receiver (8N1, LSB first) that sits directly upstream of the LED blink stage.
- Converts the serial rx pin into byte-wide, single-cycle-valid words. The remote-control logic uses these words to drive the leds bank.
- Provides glitch rejection on the start bit, framing-error detection and break (line held low) handling.

Parameters:
- CLK_FREQ, 25_000_000, system clock frequency in Hz.
- BAUD_RATE, 115200, serial bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (integer division; 217 at defaults), clocks per bit. Derived; do not override.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  reset. Asynchronous assert, active-low; all flops clear immediately on rst_n=0.
- rx  input  1  asynchronous serial line; idle level 1.
- data_out  output  8  last correctly framed byte; holds its value between frames.
- data_valid  output  1  one-cycle pulse when data_out updates.
- frame_error  output  1  one-cycle pulse when the stop bit samples 0.
- busy  output  1  high in every state other than IDLE.

Behaviour:
- Reset values:
  - data_out=8'h00, data_valid=0, frame_error=0, busy=0.
  - state=IDLE, counters=0.
  - Both synchronizer flops reset to 1 (idle line).
- Input synchronizer: rx passes through a 2-FF synchronizer; all decisions use the synced signal rx_s. This adds 2 cycles of latency.
- HALF = CLKS_PER_BIT/2 (integer division). Baud counter is 16 bits. Bit index is 3 bits.
- State machine (localparams IDLE, START, DATA, STOP, BREAK):
  - IDLE: when rx_s==0, go to START and set the counter to 0.
  - START: count up to HALF-1, then sample rx_s.
    - rx_s==0: go to DATA, counter=0, bit_idx=0.
    - rx_s==1: glitch; return to IDLE with no output pulse.
  - DATA: count up to CLKS_PER_BIT-1, then sample rx_s into shift[bit_idx] (LSB first) and reset the counter.
    - bit_idx 0..6: increment bit_idx.
    - bit_idx 7: go to STOP.
  - STOP: count up to CLKS_PER_BIT-1, then sample rx_s.
    - rx_s==1: data_out<=shift and data_valid=1 for one cycle, in the same clock edge that leaves STOP. Go to IDLE.
    - rx_s==0: frame_error=1 for one cycle; data_out unchanged. Go to BREAK.
  - BREAK: wait for rx_s==1, then go to IDLE. While the line is held low, no new frame may start.
- Latency: data_valid asserts 2 + HALF + 9*CLKS_PER_BIT (+1) cycles after the rx falling edge of the start bit.
- Back-to-back frames: a start edge arriving right after the stop-bit sample is accepted. There are no dead cycles beyond the return to IDLE.
- data_valid and frame_error are never high in the same cycle.
- rx changes mid-bit: ignored; only the centre sample counts.
- Reset mid-frame: the partial frame is discarded, no pulse is emitted, and outputs take their reset values.
- No backpressure: the consumer must accept each byte in the data_valid cycle.

Decomposition:
- Shared package/include holds:
  - state encodings (IDLE=0, START=1, DATA=2, STOP=3, BREAK=4, 3-bit);
  - the CLKS_PER_BIT/HALF derivation;
  - the default CLK_FREQ.
- These are reused by the blink stage and the future uart_tx.
- One sub-module: sync_2ff, a generic 2-flop synchronizer with a reset-value parameter, instantiated here with reset value 1.

Test Plan:
(All scenarios use CLK_FREQ=1_000_000 and BAUD_RATE=100_000, giving CLKS_PER_BIT=10 and HALF=5.)
1. Reset: hold rst_n=0 with rx=1, then release. Expect data_out=8'h00, data_valid=0, frame_error=0, busy=0. Drive rst_n low asynchronously mid-clock; outputs must clear before the next edge.
2. Single frame 8'hA5, 10 clocks per bit. Expect one data_valid pulse with data_out=8'hA5 within 2+5+90 ±2 cycles of the start edge; busy=0 afterwards.
3. Back-to-back frames 8'h01, 8'h80, 8'hFF, 8'h00 with no idle gap. Expect four data_valid pulses in order with matching data_out and no frame_error.
4. Start glitch: rx low for 3 cycles, then high. Expect no data_valid or frame_error, and a return to IDLE (busy=0) within 8 cycles.
5. Framing error: frame 8'h3C with stop bit 0, then the line held low for 50 cycles, then high, then frame 8'h5A. Expect:
   - one frame_error pulse;
   - data_out still equal to the previous value;
   - no activity during the low hold;
   - then data_valid with data_out=8'h5A.
6. Reset mid-frame: assert rst_n=0 during bit 4 of 8'hC3, release, then send 8'h12. Expect no pulse for the aborted frame, then data_valid with data_out=8'h12.
